// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the main-memory arbiter.
// Holds the arbiter state enum, block geometry defaults and word wrap.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_D = 2'd2,
    FILL_I = 2'd3
  } arb_state_t;

  localparam int BLK_WORDS_DEF = 8;
  localparam int IDX_W_DEF     = $clog2(BLK_WORDS_DEF);

  // Word index within a block, wrapping past the block end.
  // blk must be a power of two.
  function automatic int unsigned wrap_idx(
    input int unsigned start,
    input int unsigned n,
    input int unsigned blk
  );
    return (start + n) & (blk - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// fill_seq: issue/receive sequencer for one 8-word block fill.
// Ports: clk, rst_n, active (fill state), addr (latched miss address),
//   mem_valid; out issue, rd_addr, fill_we, fill_idx, last.
// Build option MEM_ARB_CRITICAL_WORD_FIRST_EN starts at the missed word.
module fill_seq
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int IDX_W     = $clog2(BLK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_valid,
  output logic              issue,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              last
);

  // iss needs one extra bit to express "all words issued".
  logic [IDX_W:0]   iss;
  logic [IDX_W-1:0] rcv;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] iss_word;
  logic [IDX_W-1:0] rcv_word;
  logic             unused_bits;

`ifdef MEM_ARB_CRITICAL_WORD_FIRST_EN
  assign start       = addr[IDX_W:1];
  assign unused_bits = addr[0];
`else
  assign start       = '0;
  assign unused_bits = ^addr[IDX_W:0];
`endif

  assign iss_word = IDX_W'(wrap_idx(32'(start),
                                    32'(iss[IDX_W-1:0]),
                                    BLK_WORDS));
  assign rcv_word = IDX_W'(wrap_idx(32'(start),
                                    32'(rcv),
                                    BLK_WORDS));

  assign issue   = active & ~iss[IDX_W];
  assign fill_we = active & mem_valid;
  assign last    = fill_we & (rcv == IDX_W'(BLK_WORDS - 1));

  assign rd_addr = issue
                 ? {addr[ADDR_W-1:IDX_W+1], iss_word, 1'b0}
                 : '0;
  assign fill_idx = fill_we ? rcv_word : '0;

  // Counters sit at zero whenever no fill is running, so a stray
  // mem_valid outside a fill cannot disturb the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss <= '0;
      rcv <= '0;
    end else if (!active) begin
      iss <= '0;
      rcv <= '0;
    end else begin
      if (issue) begin
        iss <= iss + (IDX_W+1)'(1);
      end
      if (mem_valid) begin
        rcv <= rcv + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between I-fill, D-fill and D-store.
// Ports: i_miss/i_addr -> i_fill_we/i_fill_done; d_miss/d_addr/d_wr/
//   d_wdata -> d_wr_ack/d_fill_we/d_fill_done; fill_idx/fill_data to
//   both caches; mem_enable/mem_wr/mem_addr/mem_wdata/mem_rdata/
//   mem_valid to memory. Build option MEM_ARB_CRITICAL_WORD_FIRST_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int MEM_LAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_miss,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_fill_we,
  output logic                         i_fill_done,
  input  logic                         d_miss,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic                         d_wr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_wr_ack,
  output logic                         d_fill_we,
  output logic                         d_fill_done,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         mem_enable,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_valid
);

  localparam int IDX_W = $clog2(BLK_WORDS);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              any_req;
  logic              fill_act;
  logic              seq_issue;
  logic              seq_we;
  logic              seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic [IDX_W-1:0]  seq_idx;
  logic [7:0]        unused_lat;

  // Memory latency is absorbed by the receive counter, not counted.
  assign unused_lat = 8'(MEM_LAT);

  assign any_req  = d_wr | d_miss | i_miss;
  assign fill_act = (state == FILL_D) | (state == FILL_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Store and D-miss share d_addr, so the D side wins the latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (state == IDLE && any_req) begin
      addr_q <= (d_wr | d_miss) ? d_addr : i_addr;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (d_wr) begin
          state_nx = WRITE;
        end else if (d_miss) begin
          state_nx = FILL_D;
        end else if (i_miss) begin
          state_nx = FILL_I;
        end
      end
      WRITE: begin
        state_nx = IDLE;
      end
      FILL_D, FILL_I: begin
        if (seq_last) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wr_ack    = 1'b0;
    i_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_done = 1'b0;
    fill_idx    = '0;
    unique case (state)
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = d_wdata;
        d_wr_ack   = 1'b1;
      end
      FILL_D: begin
        mem_enable  = seq_issue;
        mem_addr    = seq_addr;
        d_fill_we   = seq_we;
        d_fill_done = seq_last;
        fill_idx    = seq_idx;
      end
      FILL_I: begin
        mem_enable  = seq_issue;
        mem_addr    = seq_addr;
        i_fill_we   = seq_we;
        i_fill_done = seq_last;
        fill_idx    = seq_idx;
      end
      default: begin
      end
    endcase
  end

  assign fill_data = mem_rdata;

  fill_seq #(
    .ADDR_W   (ADDR_W),
    .BLK_WORDS(BLK_WORDS),
    .IDX_W    (IDX_W)
  ) u_fill_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (fill_act),
    .addr     (addr_q),
    .mem_valid(mem_valid),
    .issue    (seq_issue),
    .rd_addr  (seq_addr),
    .fill_we  (seq_we),
    .fill_idx (seq_idx),
    .last     (seq_last)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter.
// Memory latency model plus transaction-level expected event lists.
module tb_mem_arbiter;

  localparam int LAT = 4;
`ifdef MEM_ARB_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int RD  = 0;
  localparam int WR  = 1;
  localparam int IFL = 2;
  localparam int DFL = 3;

  typedef struct {
    int cyc;
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_fill_we, i_fill_done;
  logic        d_miss = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_wr = 1'b0;
  logic [15:0] d_wdata = '0;
  logic        d_wr_ack, d_fill_we, d_fill_done;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  logic        mv_model = 1'b0;
  logic        inj = 1'b0;
  logic [15:0] rd_model = '0;
  bit          sch_v [16];
  logic [15:0] sch_a [16];
  int          cyc = 0;
  bit          drop_i, drop_d, drop_w;
  int          bad_zero = 0;
  int          passed = 0;
  int          total = 0;
  ev_t         exp_q [$];
  ev_t         obs_q [$];

  assign mem_valid = mv_model | inj;
  assign mem_rdata = rd_model;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_addr(i_addr),
    .i_fill_we(i_fill_we), .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_wr(d_wr), .d_wdata(d_wdata), .d_wr_ack(d_wr_ack),
    .d_fill_we(d_fill_we), .d_fill_done(d_fill_done),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Cycle boundary: memory returns and requester drops, 1ns after edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    mv_model = sch_v[cyc % 16];
    rd_model = sch_v[cyc % 16] ? mdata(sch_a[cyc % 16]) : 16'h0;
    sch_v[cyc % 16] = 1'b0;
    if (drop_i) begin i_miss = 1'b0; drop_i = 1'b0; end
    if (drop_d) begin d_miss = 1'b0; drop_d = 1'b0; end
    if (drop_w) begin d_wr = 1'b0; drop_w = 1'b0; end
  end

  // Mid-cycle: memory accepts reads, monitor logs events.
  always @(negedge clk) begin
    ev_t e;
    if (mem_enable && !mem_wr) begin
      sch_v[(cyc + LAT) % 16] = 1'b1;
      sch_a[(cyc + LAT) % 16] = mem_addr;
      e = '{cyc, RD, int'(mem_addr), 0, 0};
      obs_q.push_back(e);
      if (mem_wdata != 0) bad_zero++;
    end
    if ((mem_enable && mem_wr) || d_wr_ack) begin
      e = '{cyc, WR, int'(mem_addr), int'(mem_wdata), int'(d_wr_ack)};
      obs_q.push_back(e);
      if (d_wr_ack) drop_w = 1'b1;
    end
    if (!mem_enable && (mem_wr || mem_addr != 0 || mem_wdata != 0))
      bad_zero++;
    if (i_fill_we || i_fill_done) begin
      e = '{cyc, IFL, int'(fill_idx), int'(fill_data), int'(i_fill_done)};
      obs_q.push_back(e);
      if (i_fill_done) drop_i = 1'b1;
    end
    if (d_fill_we || d_fill_done) begin
      e = '{cyc, DFL, int'(fill_idx), int'(fill_data), int'(d_fill_done)};
      obs_q.push_back(e);
      if (d_fill_done) drop_d = 1'b1;
    end
    if (!i_fill_we && !d_fill_we && fill_idx != 0) bad_zero++;
    if (fill_data !== mem_rdata) bad_zero++;
  end

  task automatic take_obs(input ev_t e, output bit hit);
    hit = 1'b0;
    for (int j = 0; j < obs_q.size(); j++) begin
      if (obs_q[j].cyc == e.cyc && obs_q[j].kind == e.kind &&
          obs_q[j].a == e.a && obs_q[j].b == e.b &&
          obs_q[j].c == e.c) begin
        obs_q.delete(j);
        hit = 1'b1;
        break;
      end
    end
  endtask

  // Block fill as the caches see it: 8 reads from the entry cycle,
  // 8 returns LAT later, done on the eighth.
  task automatic exp_fill(input int s, input int kind,
                          input logic [15:0] addr);
    logic [15:0] base;
    int st, w;
    ev_t e;
    base = addr & 16'hFFF0;
    st = CWF ? int'(addr[3:1]) : 0;
    for (int n = 0; n < 8; n++) begin
      w = (st + n) % 8;
      e = '{s + n, RD, int'(base) + 2 * w, 0, 0};
      exp_q.push_back(e);
      e = '{s + LAT + n, kind, w, int'(mdata(base + 16'(2 * w))),
            (n == 7) ? 1 : 0};
      exp_q.push_back(e);
    end
  endtask

  // Raise requests this cycle and build the expected sequence:
  // store first, then D-fill, then I-fill, each after an IDLE sample.
  task automatic launch(input bit dw, input bit dm, input bit im,
                        input logic [15:0] da, input logic [15:0] ia,
                        input logic [15:0] wd, output int t_end);
    int t;
    ev_t e;
    exp_q.delete();
    obs_q.delete();
    drop_i = 1'b0; drop_d = 1'b0; drop_w = 1'b0;
    d_addr = da; i_addr = ia; d_wdata = wd;
    d_wr = dw; d_miss = dm; i_miss = im;
    t = cyc;
    if (dw) begin
      e = '{t + 1, WR, int'(da), int'(wd), 1};
      exp_q.push_back(e);
      t = t + 2;
    end
    if (dm) begin
      exp_fill(t + 1, DFL, da);
      t = t + 13;
    end
    if (im) begin
      exp_fill(t + 1, IFL, ia);
      t = t + 13;
    end
    t_end = t;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({i_fill_we, i_fill_done, d_wr_ack, d_fill_we, d_fill_done,
         mem_enable, mem_wr} !== 7'b0)
      $display("FAIL reset_strobes: actual=%b required=0",
               {i_fill_we, i_fill_done, d_wr_ack, d_fill_we,
                d_fill_done, mem_enable, mem_wr});
    else passed++;
    total++;
    if (mem_addr !== 16'h0)
      $display("FAIL reset_mem_addr: actual=%h required=0000", mem_addr);
    else passed++;
    total++;
    if (mem_wdata !== 16'h0)
      $display("FAIL reset_mem_wdata: actual=%h required=0000", mem_wdata);
    else passed++;
    total++;
    if (fill_idx !== 3'd0)
      $display("FAIL reset_fill_idx: actual=%0d required=0", fill_idx);
    else passed++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_enable, i_fill_we, d_fill_we, d_wr_ack} !== 4'b0)
      $display("FAIL post_reset_idle: actual=%b required=0",
               {mem_enable, i_fill_we, d_fill_we, d_wr_ack});
    else passed++;
    total++;
    if (fill_data !== mem_rdata)
      $display("FAIL fill_data_follow: actual=%h required=%h",
               fill_data, mem_rdata);
    else passed++;
  endtask

  task automatic test_directed();
    bit          tdw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit          tdm [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit          tim [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] tda [4] = '{16'h0, 16'h1234, 16'h2002, 16'h003A};
    logic [15:0] tia [4] = '{16'h0040, 16'h0100, 16'h0, 16'h0};
    int t_end, bz;
    bit hit;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      bz = bad_zero;
      launch(tdw[k], tdm[k], tim[k], tda[k], tia[k], 16'hBEEF, t_end);
      repeat (t_end + 6 - cyc) @(posedge clk);
      #2;
      for (int i = 0; i < exp_q.size(); i++) begin
        take_obs(exp_q[i], hit);
        total++;
        if (hit !== 1'b1)
          $display("FAIL dir%0d_event: cyc=%0d kind=%0d a=%0h b=%0h c=%0d actual=absent required=present",
                   k, exp_q[i].cyc, exp_q[i].kind, exp_q[i].a,
                   exp_q[i].b, exp_q[i].c);
        else passed++;
      end
      total++;
      if (obs_q.size() !== 0)
        $display("FAIL dir%0d_extra: actual=%0d events (first cyc=%0d kind=%0d a=%0h) required=0",
                 k, obs_q.size(), obs_q[0].cyc, obs_q[0].kind,
                 obs_q[0].a);
      else passed++;
      total++;
      if (bad_zero !== bz)
        $display("FAIL dir%0d_idle_zero: actual=%0d required=%0d",
                 k, bad_zero, bz);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int t_end, s;
    bit hit;
    @(posedge clk); #2;
    launch(1'b0, 1'b0, 1'b1, 16'h0, 16'h0086, 16'h0, t_end);
    s = cyc + 1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc > s + 5) exp_q.delete(i);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    i_miss = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({i_fill_we, i_fill_done, d_fill_we, d_fill_done, mem_enable,
         mem_wr, d_wr_ack} !== 7'b0 || fill_idx !== 3'd0 ||
        mem_addr !== 16'h0)
      $display("FAIL rst_mid_outputs: actual=%b/%0d/%h required=0/0/0000",
               {i_fill_we, i_fill_done, d_fill_we, d_fill_done,
                mem_enable, mem_wr, d_wr_ack}, fill_idx, mem_addr);
    else passed++;
    repeat (6) @(posedge clk);
    #2;
    for (int i = 0; i < exp_q.size(); i++) begin
      take_obs(exp_q[i], hit);
      total++;
      if (hit !== 1'b1)
        $display("FAIL rst_mid_event: cyc=%0d kind=%0d a=%0h b=%0h c=%0d actual=absent required=present",
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].a,
                 exp_q[i].b, exp_q[i].c);
      else passed++;
    end
    total++;
    if (obs_q.size() !== 0)
      $display("FAIL rst_mid_extra: actual=%0d events (first cyc=%0d kind=%0d) required=0",
               obs_q.size(), obs_q[0].cyc, obs_q[0].kind);
    else passed++;
  endtask

  task automatic test_idle_valid();
    int t_end;
    bit hit;
    @(posedge clk); #2;
    inj = 1'b1;
    @(negedge clk);
    total++;
    if ({i_fill_we, d_fill_we, i_fill_done, d_fill_done} !== 4'b0)
      $display("FAIL idle_valid_strobe: actual=%b required=0",
               {i_fill_we, d_fill_we, i_fill_done, d_fill_done});
    else passed++;
    total++;
    if (fill_idx !== 3'd0)
      $display("FAIL idle_valid_idx: actual=%0d required=0", fill_idx);
    else passed++;
    @(posedge clk); #2;
    inj = 1'b0;
    launch(1'b0, 1'b0, 1'b1, 16'h0, 16'h031C, 16'h0, t_end);
    repeat (t_end + 6 - cyc) @(posedge clk);
    #2;
    for (int i = 0; i < exp_q.size(); i++) begin
      take_obs(exp_q[i], hit);
      total++;
      if (hit !== 1'b1)
        $display("FAIL idle_valid_after: cyc=%0d kind=%0d a=%0h b=%0h c=%0d actual=absent required=present",
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].a,
                 exp_q[i].b, exp_q[i].c);
      else passed++;
    end
    total++;
    if (obs_q.size() !== 0)
      $display("FAIL idle_valid_extra: actual=%0d events required=0",
               obs_q.size());
    else passed++;
  endtask

  task automatic test_random();
    int t_end, bz, combo;
    bit hit;
    for (int k = 0; k < 8; k++) begin
      combo = $urandom_range(1, 7);
      @(posedge clk); #2;
      bz = bad_zero;
      launch(combo[0], combo[1], combo[2], 16'($urandom()),
             16'($urandom()), 16'($urandom()), t_end);
      repeat (t_end + 6 - cyc) @(posedge clk);
      #2;
      for (int i = 0; i < exp_q.size(); i++) begin
        take_obs(exp_q[i], hit);
        total++;
        if (hit !== 1'b1)
          $display("FAIL rnd%0d_event: cyc=%0d kind=%0d a=%0h b=%0h c=%0d actual=absent required=present",
                   k, exp_q[i].cyc, exp_q[i].kind, exp_q[i].a,
                   exp_q[i].b, exp_q[i].c);
        else passed++;
      end
      total++;
      if (obs_q.size() !== 0)
        $display("FAIL rnd%0d_extra: actual=%0d events (first cyc=%0d kind=%0d) required=0",
                 k, obs_q.size(), obs_q[0].cyc, obs_q[0].kind);
      else passed++;
      total++;
      if (bad_zero !== bz)
        $display("FAIL rnd%0d_idle_zero: actual=%0d required=%0d",
                 k, bad_zero, bz);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sch_v[i] = 1'b0;
      sch_a[i] = 16'h0;
    end
    test_reset();
    test_directed();
    test_reset_mid_fill();
    test_idle_valid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared main-memory controller for the cache-based pipeline. Arbitrates between instruction-cache miss fills, data-cache miss fills and data-cache write-through stores. Sequences each granted miss as an 8-word block read against the single pipelined main memory, and steers the returned words into the requesting cache. Sits between the two caches and the main memory model, below the IF and MEM stages.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- BLK_WORDS, 8, words per cache block (power of 2; index width IDX_W = log2(BLK_WORDS))
- MEM_LAT, 4, cycles from read issue to `mem_valid`; the bench model honours this, the arbiter does not count it

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_miss  in  1  I-cache miss; level, held until `i_fill_done`
- i_addr  in  ADDR_W  I-cache miss byte address
- i_fill_we  out  1  write returned word into I-cache
- i_fill_done  out  1  last word of I-fill
- d_miss  in  1  D-cache miss; level, held until `d_fill_done`
- d_addr  in  ADDR_W  D-cache miss or store byte address
- d_wr  in  1  write-through store request; level, held until `d_wr_ack`
- d_wdata  in  DATA_W  store data
- d_wr_ack  out  1  store issued to memory
- d_fill_we  out  1  write returned word into D-cache
- d_fill_done  out  1  last word of D-fill
- fill_idx  out  IDX_W  word index within block of current fill word
- fill_data  out  DATA_W  returned word (= `mem_rdata`)
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  write (1) or read (0)
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  `mem_rdata` valid

## Operation
- FSM states: IDLE, WRITE, FILL_D, FILL_I.
- IDLE priority, evaluated each cycle: `d_wr` → WRITE, else `d_miss` → FILL_D, else `i_miss` → FILL_I. The granted address is latched on the transition edge. No preemption once a state is entered.
- WRITE (one cycle):
  - drives `mem_enable=1`, `mem_wr=1`, `mem_addr=latched addr`, `mem_wdata=d_wdata`, `d_wr_ack=1`
  - → IDLE
- FILL_x:
  - Issue counter `iss` (0..BLK_WORDS) and receive counter `rcv` (0..BLK_WORDS-1).
  - While `iss<BLK_WORDS`: `mem_enable=1`, `mem_wr=0`, `mem_addr={blk_base, word(iss), 1'b0}`; `iss` increments each cycle.
  - On `mem_valid`: `x_fill_we=1`, `fill_idx=word(rcv)`, `rcv` increments.
  - When `mem_valid && rcv==BLK_WORDS-1`: `x_fill_done=1` in that same cycle → IDLE.
- `word(n) = n` (block-aligned order); see Configuration for the alternative.
- `blk_base = addr[ADDR_W-1:IDX_W+1]`. Word index arithmetic is modulo BLK_WORDS.
- `mem_valid` is ignored in IDLE and WRITE; no fill strobe is produced there.
- A requester must drop its level request on the edge after its done/ack pulse; the arbiter re-samples requests in IDLE only.
- Outputs not driven by the current state are 0.

## Timing
- Reset: state IDLE, `iss=rcv=0`, latched addr 0. All outputs 0 (`fill_data` follows `mem_rdata`).
- Request high at edge E → state entered at E+1.
- Fill, with entry at cycle 0:
  - reads issued cycles 0..7
  - words returned cycles 4..11 at MEM_LAT=4
  - `done` in cycle 11; IDLE at cycle 12
  - minimum 13 cycles request-to-IDLE
- Store: 2 cycles (IDLE sample, WRITE).
- Simultaneous `d_wr`+`d_miss`+`i_miss`: store, then D-fill, then I-fill; the pending I-miss waits, with no starvation bound required.
- Reset asserted mid-fill: immediate return to IDLE. Late `mem_valid` returns are ignored. Caches restart misses after reset.

## Configuration
- `MEM_ARB_CRITICAL_WORD_FIRST_EN`
  - Defined: `word(n) = (addr[IDX_W:1] + n) mod BLK_WORDS`. The first issued and first returned word is the missed word; wraps past the block end.
  - Undefined: `word(n) = n`, and `addr[IDX_W:1]` is ignored.
- `fill_idx` always reports the true word index, so the caches are identical in both builds.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, WRITE, FILL_D, FILL_I)
  - BLK_WORDS/IDX_W defaults
  - word-index wrap function
- Sub-module `fill_seq`: `iss`/`rcv` counters, start-word offset, address and index generation, last-word detect. The top holds the FSM, priority logic and output steering.

## Test plan
- Reset, then `i_miss` with `i_addr=0x0040` → reads to 0x0040..0x004E in cycles 0..7; `i_fill_we` with `fill_idx` 0..7 in cycles 4..11; `i_fill_done` in cycle 11; `d_*` strobes stay 0.
- `d_miss` (addr 0x1234) and `i_miss` (addr 0x0100) raised in the same cycle → D-fill of block 0x1230 completes first; I-fill of 0x0100 starts the cycle after IDLE is re-entered.
- `d_wr`, `d_addr=0x2002`, `d_wdata=0xBEEF`, while `d_miss` is also high → WRITE cycle with `mem_wr=1`, `mem_addr=0x2002`, `mem_wdata=0xBEEF`, `d_wr_ack=1`; D-fill follows.
- With `MEM_ARB_CRITICAL_WORD_FIRST_EN`, `d_miss` at 0x003A → issue order 0x003A, 0x003C, 0x003E, 0x0030 … 0x0038; `fill_idx` sequence 5,6,7,0,1,2,3,4.
- `rst_n` low in fill cycle 6, released at cycle 8 while the model still returns 2 words → no fill strobes, state IDLE, all outputs 0.
- `mem_valid` pulse injected while IDLE → no `*_fill_we`, counters unchanged.
